uart_tx_mmio: RTL

MMIO-mapped UART transmitter. It sits downstream of the core, in parallel with the LED block, and consumes the core's `mmio_out_addr`/`mmio_out` write bus. Bytes written to `UART_ADDR` are queued in a small FIFO and serialized 8N1, LSB first, on the board's `uart_tx` pin. Status outputs are provided for debug and future MMIO readback.

---
 rtl/uart_tx_mmio_if.sv | 25 ++
 rtl/uart_tx_mmio.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio_if.sv
// Core MMIO write bus into the UART transmitter plus its serial line and status outputs.
// Master drives the held address/data pair; slave returns the line and FIFO status.
interface uart_tx_mmio_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]      mmio_out_addr;
    logic [7:0]       mmio_out;
    logic             uart_tx;
    logic             tx_busy;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    modport master (
        output mmio_out_addr, mmio_out,
        input  uart_tx, tx_busy, fifo_full, fifo_count, overflow
    );

    modport slave (
        input  mmio_out_addr, mmio_out,
        output uart_tx, tx_busy, fifo_full, fifo_count, overflow
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// MMIO-fed 8N1 UART transmitter: a new address/data pair at UART_ADDR enqueues one byte.
// Line falls two cycles after the write; a full FIFO with no pop drops the write and sets sticky overflow.
module uart_tx_mmio #(
    parameter int          CLK_HZ     = 27000000,
    parameter int          BAUD       = 115200,
    parameter logic [15:0] UART_ADDR  = 16'hFF01,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic           clock,
    input  logic           reset,
    uart_tx_mmio_if.slave  bus
);
    localparam int DIVISOR = CLK_HZ / BAUD;
    localparam int BAUD_W  = $clog2(DIVISOR);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       prev_addr_q, prev_addr_d;
    logic [7:0]        prev_data_q, prev_data_d;
    logic              uart_tx_q, uart_tx_d;
    logic              tx_busy_q, tx_busy_d;
    logic              fifo_full_q, fifo_full_d;
    logic              overflow_q, overflow_d;

    logic [7:0]        mem_q [FIFO_DEPTH];

    logic              wr_evt_vld;
    logic              push_vld;
    logic              pop_vld;
    logic              fifo_empty;
    logic              baud_end;
    logic [7:0]        wr_dat;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pop_vld     = 1'b0;
        wr_dat      = bus.mmio_out;
        prev_addr_d = bus.mmio_out_addr;
        prev_data_d = bus.mmio_out;

        // The bus has no strobe: a write is a change of the held pair while pointing at UART_ADDR.
        wr_evt_vld = (bus.mmio_out_addr == UART_ADDR) &&
                     ((prev_addr_q != UART_ADDR) || (prev_data_q != bus.mmio_out));
        fifo_empty = (count_q == '0);
        baud_end   = (baud_q == BAUD_LAST);

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_vld = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so queued bytes leave with no idle gap.
                    if (!fifo_empty) begin
                        pop_vld = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        push_vld   = wr_evt_vld && (!fifo_full_q || pop_vld);
        overflow_d = overflow_q || (wr_evt_vld && fifo_full_q && !pop_vld);

        if (pop_vld) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_vld) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        count_d     = count_q + CNT_W'(push_vld) - CNT_W'(pop_vld);
        fifo_full_d = (count_d == CNT_FULL);

        // Line level is derived from the next state so the pin itself comes straight off a flop.
        unique case (state_d)
            START:   uart_tx_d = 1'b0;
            DATA:    uart_tx_d = shift_d[bit_d];
            default: uart_tx_d = 1'b1;
        endcase
        tx_busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            prev_addr_q <= 16'h0000;
            prev_data_q <= 8'h00;
            uart_tx_q   <= 1'b1;
            tx_busy_q   <= 1'b0;
            fifo_full_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            prev_addr_q <= prev_addr_d;
            prev_data_q <= prev_data_d;
            uart_tx_q   <= uart_tx_d;
            tx_busy_q   <= tx_busy_d;
            fifo_full_q <= fifo_full_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_vld && !reset) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

    assign bus.uart_tx    = uart_tx_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.fifo_full  = fifo_full_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;

endmodule
